sysforled_cpu_div_cell: RTL and testbench

SYSFORLED_CPU_DIV_CELL -- requirements
Module: sysforled_cpu_div_cell

---
 rtl/sysforled_cpu_div_cell.sv | 127 ++++++++++++
 tb/tb_sysforled_cpu_div_cell.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sysforled_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, quotient or remainder.
// One step per M_en-high clock; M_en low freezes every register.
module sysforled_cpu_div_cell #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_start,
  input  logic              E_signed,
  input  logic              E_rem_sel,
  input  logic              M_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes the quotient
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              rsel_q, rsel_d, dz_q, dz_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              dbz_q, dbz_d;

  logic              accept, a_neg, b_neg, ge;
  logic [DATA_W-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [DATA_W:0]   rem_sh;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rsel_d   = rsel_q;
    dz_d     = dz_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    accept = M_en && E_start && (state_q == S_IDLE || state_q == S_DONE);
    a_neg  = E_signed && E_src1[DATA_W-1];
    b_neg  = E_signed && E_src2[DATA_W-1];
    a_mag  = a_neg ? -E_src1 : E_src1;
    b_mag  = b_neg ? -E_src2 : E_src2;

    rem_sh = {rem_q, dvd_q[DATA_W-1]};
    ge     = rem_sh >= {1'b0, dvs_q};

    // A zero divisor leaves rem_q = |E_src1|, so re-applying the dividend sign
    // reproduces the original E_src1 without storing it.
    q_fix  = dz_q ? '1 : ((sa_q ^ sb_q) ? -dvd_q : dvd_q);
    r_fix  = sa_q ? -rem_q : rem_q;

    if (accept) begin
      dvd_d   = a_mag;
      dvs_d   = b_mag;
      rem_d   = '0;
      sa_d    = a_neg;
      sb_d    = b_neg;
      rsel_d  = E_rem_sel;
      dz_d    = (E_src2 == '0);
      cnt_d   = '0;
      state_d = S_ITER;
    end else if (M_en) begin
      case (state_q)
        S_ITER: begin
          rem_d = ge ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ge};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = rsel_q ? r_fix : q_fix;
          dbz_d    = dz_q;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rsel_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rsel_q   <= rsel_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sysforled_cpu_div_cell.sv
// Directed bench for sysforled_cpu_div_cell: vector table plus handshake, stall and reset sequences.
module tb_sysforled_cpu_div_cell;

  logic        clk;
  logic        reset;
  logic [31:0] E_src1, E_src2;
  logic        E_start, E_signed, E_rem_sel, M_en;
  logic        busy, done, div_by_zero;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;

  sysforled_cpu_div_cell #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_src1     (E_src1),
    .E_src2     (E_src2),
    .E_start    (E_start),
    .E_signed   (E_signed),
    .E_rem_sel  (E_rem_sel),
    .M_en       (M_en),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        rsel;
    logic [31:0] exp_res;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one time unit after a clock edge; returns one unit after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic rsel);
    E_src1    = a;
    E_src2    = b;
    E_signed  = sgn;
    E_rem_sel = rsel;
    E_start   = 1'b1;
    @(posedge clk); #1;
    E_start   = 1'b0;
  endtask

  // Edge count includes the accepting edge; bounded so a stuck DUT still ends.
  task automatic wait_done(input int e0, output int edges);
    edges = e0;
    while (!done && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  int edges;

  initial begin
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, 32'd14,       1'b0};
    vecs[1]  = '{32'd100,      32'd7,        1'b0, 1'b1, 32'd2,        1'b0};
    vecs[2]  = '{-32'sd100,    32'd7,        1'b1, 1'b0, 32'hFFFFFFF2, 1'b0};
    vecs[3]  = '{-32'sd100,    32'd7,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{32'd100,      -32'sd7,      1'b1, 1'b0, 32'hFFFFFFF2, 1'b0};
    vecs[5]  = '{32'd100,      -32'sd7,      1'b1, 1'b1, 32'd2,        1'b0};
    vecs[6]  = '{32'h1234,     32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{32'h1234,     32'd0,        1'b0, 1'b1, 32'h1234,     1'b1};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b0};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0,        1'b0};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0};
    vecs[11] = '{-32'sd7,      32'd0,        1'b1, 1'b1, 32'hFFFFFFF9, 1'b1};

    reset = 1'b1; M_en = 1'b1; E_start = 1'b1;
    E_src1 = 32'd100; E_src2 = 32'd7; E_signed = 1'b0; E_rem_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(busy),        32'd0);
    chk("reset_done",   32'(done),        32'd0);
    chk("reset_result", result,           32'd0);
    chk("reset_dbz",    32'(div_by_zero), 32'd0);
    reset = 1'b0; E_start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rsel);
      wait_done(1, edges);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].exp_dz));
      chk($sformatf("vec%0d_latency", i), 32'(edges), 32'd34);
    end

    // M_en low while in DONE holds done, busy and result.
    M_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("freeze_done",   32'(done), 32'd1);
    chk("freeze_busy",   32'(busy), 32'd1);
    chk("freeze_result", result,    32'hFFFFFFF9);
    M_en = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);

    // Second start five cycles in must not disturb the operation in flight.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start_op(32'd50, 32'd5, 1'b0, 1'b1);
    wait_done(6, edges);
    chk("ignore_result",  result, 32'd14);
    chk("ignore_latency", 32'(edges), 32'd34);

    // Start accepted in DONE goes straight back to ITER.
    start_op(-32'sd100, 32'd7, 1'b1, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(1, edges);
    chk("b2b_result",  result, 32'hFFFFFFFE);
    chk("b2b_latency", 32'(edges), 32'd34);

    // Ten stalled cycles mid-ITER add exactly ten edges of latency.
    @(posedge clk); #1;
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    M_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_done", 32'(done), 32'd0);
    M_en = 1'b1;
    wait_done(15, edges);
    chk("stall_result",  result, 32'd14);
    chk("stall_latency", 32'(edges), 32'd44);

    // Asynchronous reset mid-ITER clears outputs without waiting for a clock.
    start_op(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy",   32'(busy),        32'd0);
    chk("midrst_done",   32'(done),        32'd0);
    chk("midrst_result", result,           32'd0);
    chk("midrst_dbz",    32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_op(32'd1000, 32'd3, 1'b0, 1'b1);
    wait_done(1, edges);
    chk("postrst_result",  result, 32'd1);
    chk("postrst_latency", 32'(edges), 32'd34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
